// File: rtl/stress_ramp_sequencer_if.sv
// Control/status bundle between test-control logic and the stress ramp sequencer.
// The sequencer uses the slave view; the test controller drives the master view.
interface stress_ramp_sequencer_if #(
    parameter int unsigned NUM_BANKS = 8
);
    localparam int unsigned ActW = $clog2(NUM_BANKS + 1);

    logic                  start;
    logic                  abort;
    logic [31:0]           hold_cycles;
    logic [NUM_BANKS-1:0]  bank_enable;
    logic [ActW-1:0]       active_banks;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic [31:0]           elapsed;

    modport master (
        output start, abort, hold_cycles,
        input  bank_enable, active_banks, busy, done, aborted, elapsed
    );

    modport slave (
        input  start, abort, hold_cycles,
        output bank_enable, active_banks, busy, done, aborted, elapsed
    );
endinterface

// File: rtl/stress_ramp_sequencer.sv
// Steps stress-bank enables on one at a time, holds, then steps them off one at a time,
// so a large toggling array never starts or stops all at once.
module stress_ramp_sequencer #(
    parameter int unsigned NUM_BANKS   = 8,
    parameter int unsigned STEP_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    stress_ramp_sequencer_if.slave   bus
);
    localparam int unsigned ActW  = $clog2(NUM_BANKS + 1);
    localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [NUM_BANKS-1:0] Bank0 = 1;

    typedef enum logic [1:0] {StIdle, StRampUp, StHold, StRampDown} state_e;

    state_e               state_q;
    logic [StepW-1:0]     step_q;
    logic [31:0]          hold_q;
    logic [NUM_BANKS-1:0] en_q;
    logic [ActW-1:0]      act_q;
    logic                 done_q;
    logic                 aborted_q;
    logic [31:0]          elapsed_q;

    logic                 step_last;
    logic [NUM_BANKS-1:0] en_up;
    logic [NUM_BANKS-1:0] en_dn;

    always_comb begin
        step_last = (step_q == StepW'(STEP_CYCLES - 1));
        en_up     = (en_q << 1) | Bank0;
        en_dn     = en_q >> 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            step_q    <= '0;
            hold_q    <= '0;
            en_q      <= '0;
            act_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            elapsed_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && elapsed_q != '1) begin
                elapsed_q <= elapsed_q + 32'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.abort) begin
                        hold_q    <= bus.hold_cycles;
                        step_q    <= '0;
                        en_q      <= Bank0;
                        act_q     <= ActW'(1);
                        elapsed_q <= '0;
                        aborted_q <= 1'b0;
                        state_q   <= StRampUp;
                    end
                end
                StRampUp: begin
                    if (!step_last) begin
                        step_q <= step_q + StepW'(1);
                    end else begin
                        step_q <= '0;
                        if (!en_q[NUM_BANKS-1]) begin
                            en_q  <= en_up;
                            act_q <= act_q + ActW'(1);
                        end else if (hold_q != '0) begin
                            state_q <= StHold;
                        end else begin
                            // Zero hold: the HOLD exit edge doubles as the first ramp-down step.
                            en_q    <= en_dn;
                            act_q   <= act_q - ActW'(1);
                            state_q <= StRampDown;
                            if (act_q == ActW'(1)) begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                StHold: begin
                    if (hold_q == 32'd1) begin
                        step_q  <= '0;
                        en_q    <= en_dn;
                        act_q   <= act_q - ActW'(1);
                        state_q <= StRampDown;
                        if (act_q == ActW'(1)) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        hold_q <= hold_q - 32'd1;
                    end
                end
                StRampDown: begin
                    if (!step_last) begin
                        step_q <= step_q + StepW'(1);
                    end else begin
                        step_q <= '0;
                        en_q   <= en_dn;
                        act_q  <= act_q - ActW'(1);
                        if (act_q == ActW'(1)) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Abort overrides whatever the state logic above decided for this edge.
            if (bus.abort && state_q != StIdle) begin
                state_q   <= StIdle;
                en_q      <= '0;
                act_q     <= '0;
                done_q    <= 1'b0;
                aborted_q <= 1'b1;
            end
        end
    end

    assign bus.bank_enable  = en_q;
    assign bus.active_banks = act_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.elapsed      = elapsed_q;
endmodule

// File: tb/tb_stress_ramp_sequencer.sv
// Directed bench for stress_ramp_sequencer with 4 banks and 4-cycle steps.
module tb_stress_ramp_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    stress_ramp_sequencer_if #(.NUM_BANKS(4)) bus ();

    stress_ramp_sequencer #(
        .NUM_BANKS   (4),
        .STEP_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept edge N happens inside; returns 1ns after N with start dropped.
    task automatic start_run(input logic [31:0] h);
        bus.hold_cycles = h;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({bus.bank_enable, bus.active_banks, bus.busy, bus.done, bus.aborted} !== 10'd0
            || bus.elapsed !== 32'd0) begin
            failures++;
            $display("FAIL reset_init: en=%b act=%0d busy=%b done=%b ab=%b el=%0d, want all 0",
                     bus.bank_enable, bus.active_banks, bus.busy, bus.done, bus.aborted,
                     bus.elapsed);
        end
        start_run(32'd10);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.bank_enable !== 4'b0011) begin
            failures++;
            $display("FAIL reset_prerun_en: got %b want 0011", bus.bank_enable);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({bus.bank_enable, bus.active_banks, bus.busy, bus.done} !== 9'd0
            || bus.elapsed !== 32'd0) begin
            failures++;
            $display("FAIL reset_async: en=%b act=%0d busy=%b done=%b el=%0d, want all 0",
                     bus.bank_enable, bus.active_banks, bus.busy, bus.done, bus.elapsed);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.bank_enable !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle: busy=%b en=%b want 0 0000", bus.busy, bus.bank_enable);
        end
    endtask

    task automatic test_normal_run;
        logic [3:0] exp_en;
        int         n;
        start_run(32'd10);
        checks++;
        if (bus.bank_enable !== 4'b0001 || bus.elapsed !== 32'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL normal_accept: en=%b el=%0d busy=%b want 0001 0 1",
                     bus.bank_enable, bus.elapsed, bus.busy);
        end
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            if      (t < 4)  exp_en = 4'b0001;
            else if (t < 8)  exp_en = 4'b0011;
            else if (t < 12) exp_en = 4'b0111;
            else if (t < 26) exp_en = 4'b1111;
            else if (t < 30) exp_en = 4'b0111;
            else if (t < 34) exp_en = 4'b0011;
            else if (t < 38) exp_en = 4'b0001;
            else             exp_en = 4'b0000;
            n = 0;
            for (int b = 0; b < 4; b++) n += int'(exp_en[b]);
            checks++;
            if (bus.bank_enable !== exp_en) begin
                failures++;
                $display("FAIL normal_en@N+%0d: got %b want %b", t, bus.bank_enable, exp_en);
            end
            checks++;
            if (bus.active_banks !== 3'(n)) begin
                failures++;
                $display("FAIL normal_act@N+%0d: got %0d want %0d", t, bus.active_banks, n);
            end
            checks++;
            if (bus.busy !== (t < 38) || bus.done !== (t == 38)) begin
                failures++;
                $display("FAIL normal_busy_done@N+%0d: got %b%b want %b%b", t, bus.busy,
                         bus.done, (t < 38), (t == 38));
            end
            checks++;
            if (bus.elapsed !== 32'((t < 38) ? t : 38)) begin
                failures++;
                $display("FAIL normal_elapsed@N+%0d: got %0d want %0d", t, bus.elapsed,
                         (t < 38) ? t : 38);
            end
        end
    endtask

    task automatic test_zero_hold;
        logic [3:0] exp_en;
        start_run(32'd0);
        for (int t = 1; t <= 30; t++) begin
            @(posedge clk); #1;
            if      (t < 4)  exp_en = 4'b0001;
            else if (t < 8)  exp_en = 4'b0011;
            else if (t < 12) exp_en = 4'b0111;
            else if (t < 16) exp_en = 4'b1111;
            else if (t < 20) exp_en = 4'b0111;
            else if (t < 24) exp_en = 4'b0011;
            else if (t < 28) exp_en = 4'b0001;
            else             exp_en = 4'b0000;
            checks++;
            if (bus.bank_enable !== exp_en) begin
                failures++;
                $display("FAIL zero_en@N+%0d: got %b want %b", t, bus.bank_enable, exp_en);
            end
            checks++;
            if (bus.done !== (t == 28) || bus.busy !== (t < 28)) begin
                failures++;
                $display("FAIL zero_busy_done@N+%0d: got %b%b want %b%b", t, bus.busy,
                         bus.done, (t < 28), (t == 28));
            end
        end
        checks++;
        if (bus.elapsed !== 32'd28) begin
            failures++;
            $display("FAIL zero_elapsed: got %0d want 28", bus.elapsed);
        end
    endtask

    task automatic test_abort;
        start_run(32'd10);
        checks++;
        if (bus.aborted !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear0: got %b want 0", bus.aborted);
        end
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (bus.bank_enable !== 4'b0111) begin
            failures++;
            $display("FAIL abort_pre_en: got %b want 0111", bus.bank_enable);
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++;
        if (bus.bank_enable !== 4'b0000 || bus.active_banks !== 3'd0 || bus.busy !== 1'b0
            || bus.aborted !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_edge: en=%b act=%0d busy=%b ab=%b done=%b want 0000 0 0 1 0",
                     bus.bank_enable, bus.active_banks, bus.busy, bus.aborted, bus.done);
        end
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.aborted !== 1'b1 || bus.elapsed !== 32'd10) begin
                failures++;
                $display("FAIL abort_after: done=%b ab=%b el=%0d want 0 1 10", bus.done,
                         bus.aborted, bus.elapsed);
            end
        end
        start_run(32'd10);
        checks++;
        if (bus.aborted !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart: ab=%b busy=%b want 0 1", bus.aborted, bus.busy);
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.aborted !== 1'b1) begin
            failures++;
            $display("FAIL abort_again: busy=%b ab=%b want 0 1", bus.busy, bus.aborted);
        end
    endtask

    task automatic test_priorities;
        bus.hold_cycles = 32'd0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int t = 1; t <= 29; t++) begin
            @(posedge clk); #1;
            if (t == 4) begin
                checks++;
                if (bus.bank_enable !== 4'b0011 || bus.elapsed !== 32'd4) begin
                    failures++;
                    $display("FAIL prio_ignore_start: en=%b el=%0d want 0011 4",
                             bus.bank_enable, bus.elapsed);
                end
            end
            if (t == 28) begin
                checks++;
                if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.bank_enable !== 4'b0000) begin
                    failures++;
                    $display("FAIL prio_done: done=%b busy=%b en=%b want 1 0 0000",
                             bus.done, bus.busy, bus.bank_enable);
                end
            end
        end
        checks++;
        if (bus.bank_enable !== 4'b0001 || bus.busy !== 1'b1 || bus.elapsed !== 32'd0
            || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL prio_restart: en=%b busy=%b el=%0d done=%b want 0001 1 0 0",
                     bus.bank_enable, bus.busy, bus.elapsed, bus.done);
        end
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.aborted !== 1'b1) begin
            failures++;
            $display("FAIL prio_abort: busy=%b ab=%b want 0 1", bus.busy, bus.aborted);
        end
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.bank_enable !== 4'b0000 || bus.aborted !== 1'b1) begin
                failures++;
                $display("FAIL prio_start_abort: busy=%b en=%b ab=%b want 0 0000 1",
                         bus.busy, bus.bank_enable, bus.aborted);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic test_long_hold;
        start_run(32'hFFFF_FFFF);
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (bus.bank_enable !== 4'b1111 || bus.busy !== 1'b1 || bus.elapsed !== 32'd100) begin
            failures++;
            $display("FAIL long_hold: en=%b busy=%b el=%0d want 1111 1 100",
                     bus.bank_enable, bus.busy, bus.elapsed);
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++;
        if (bus.bank_enable !== 4'b0000 || bus.busy !== 1'b0 || bus.aborted !== 1'b1
            || bus.elapsed !== 32'd101 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL long_abort: en=%b busy=%b ab=%b el=%0d done=%b want 0000 0 1 101 0",
                     bus.bank_enable, bus.busy, bus.aborted, bus.elapsed, bus.done);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.hold_cycles = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_normal_run();
        test_zero_hold();
        test_abort();
        test_priorities();
        test_long_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stress_ramp_sequencer.md
# stress_ramp_sequencer

Sequences a group of pseudorandom flip-flop stress banks (each a pseudorandom_ff-style array) through a controlled power profile: banks switch on one at a time, all hold for a programmable time, then switch off one at a time. The stepped ramp prevents supply current surges when a large stress array starts or stops toggling. The block sits between the test-control logic and the per-bank enables.

## Interface
- NUM_BANKS, 8, number of stress banks controlled; legal range 1..32.
- STEP_CYCLES, 256, dwell time in cycles between ramp steps; must be ≥1.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled each cycle; starts a run when sampled high in IDLE.
- abort  in  1  level; sampled each cycle; kills a run in progress.
- hold_cycles  in  32  HOLD duration in cycles; latched when start is accepted.
- bank_enable  out  NUM_BANKS  thermometer-coded bank enables; bit 0 is on first and off last.
- active_banks  out  $clog2(NUM_BANKS+1)  popcount of bank_enable, registered alongside it.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse on normal run completion.
- aborted  out  1  sticky; set by abort, cleared when the next start is accepted.
- elapsed  out  32  cycles since start acceptance; saturating.

## Operation
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN. After reset the state is IDLE and every output is 0.
- **IDLE:** start=1 and abort=0 accepts a run. On that edge:
  - latch hold_cycles and clear the step counter;
  - set bank_enable=1, elapsed=0, aborted=0;
  - enter RAMP_UP.
- **RAMP_UP:** every STEP_CYCLES cycles, set the next-higher enable bit. After the last bank has dwelt STEP_CYCLES cycles:
  - go to HOLD if latched hold ≠ 0;
  - otherwise go directly to RAMP_DOWN.
- **HOLD:** all banks enabled for exactly the latched hold count of cycles, then RAMP_DOWN.
- **RAMP_DOWN:** on the entry edge, clear the highest set bit. Then clear one more bit every STEP_CYCLES cycles. The edge that clears bit 0 also:
  - returns the state to IDLE;
  - asserts done for one cycle.
- **Abort:** abort=1 in any non-IDLE state causes, on the next edge:
  - bank_enable=0, state=IDLE, aborted=1;
  - no done pulse.
- **Priorities and ignored inputs:**
  - abort takes priority over everything;
  - start while busy is ignored;
  - start and abort both high in IDLE: no run starts and aborted is unchanged.
- **elapsed:** increments by 1 every cycle while busy and saturates at 0xFFFF_FFFF. It holds its value after done or abort until the next accepted start.
- **NUM_BANKS=1:**
  - RAMP_UP lasts STEP_CYCLES cycles;
  - the RAMP_DOWN entry edge clears bit 0 and completes the run.
- **Counter widths:**
  - step counter: $clog2(STEP_CYCLES) bits, minimum 1, wraps at STEP_CYCLES-1;
  - hold counter: 32 bits, counts down.
- **Reset mid-run:** all outputs clear immediately (asynchronously) and the state becomes IDLE. Any latched hold value is discarded.

## Timing
- Let N be the edge that accepts start, S = STEP_CYCLES, B = NUM_BANKS, H = latched hold value.
- Bank k enables at edge N + k·S, for k = 0..B-1.
- HOLD entry: N + B·S.
- RAMP_DOWN entry: N + B·S + H. This edge clears bit B-1.
- Bit j clears at N + B·S + H + (B-1-j)·S.
- done is high for the cycle after edge N + B·S + H + (B-1)·S; busy falls on that same edge.
- elapsed at done equals the total busy cycle count, (2B-1)·S + H.
- Output latency is zero beyond the registered edge: bank_enable, active_banks and busy all update on the same edge.
- Abort latency: exactly one edge from abort sampled high to bank_enable=0.

## Test plan
- **Reset:** assert reset mid-cycle with outputs nonzero -> all outputs read 0 before the next clk edge; state is IDLE.
- **Normal run** (B=4, S=4, hold=10; start at edge N):
  - enables 0001/0011/0111/1111 at N/N+4/N+8/N+12;
  - HOLD at N+16; bit 3 clears at N+26, then 0011 at N+30, 0001 at N+34, 0000 at N+38;
  - done pulses one cycle; elapsed=38.
- **Zero hold** (hold=0, B=4, S=4) -> RAMP_DOWN entered at N+16 (bit 3 clears there); done after edge N+28; elapsed=28.
- **Abort** at N+9 with bank_enable=0111 -> bank_enable=0000 at N+10; aborted=1; done never pulses; the next start clears aborted.
- **Priorities:** start held high through a whole run -> exactly one run, and a new run starts on the first IDLE cycle. start and abort together in IDLE -> no run and busy stays 0.
- **elapsed saturation:** hold=0xFFFF_FFFF -> elapsed sticks at 0xFFFF_FFFF while the run continues; an abort ends the run.
